// File: rtl/fpm_pkg.sv
// fpm_pkg: shared constants, operand classes and the stage-1 pipeline record
// for the fp32_multiplier datapath.
// Build option: FPM_ROUND_NEAREST_EN selects round-to-nearest-even (see fpm_norm_round).
package fpm_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXPS_W   = 10;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] QNAN = 32'h7FFF_FFFF;

    // Operand class, also reused as the class of the final result
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } opClass_e;

    // Everything stage 2 needs to finish the product
    typedef struct packed {
        opClass_e                  cls;
        logic                      sign;
        logic signed [EXPS_W-1:0]  expSum;
        logic [47:0]               mant;
    } stage1_t;

    // Denormals are treated as zero, so exp==0 alone means ZERO
    function automatic opClass_e classify(input logic [31:0] x);
        opClass_e c;
        if (x[30:23] == 8'hFF) begin
            c = (x[22:0] != 23'd0) ? NAN : INF;
        end else if (x[30:23] == 8'h00) begin
            c = ZERO;
        end else begin
            c = NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/fpm_norm_round.sv
// fpm_norm_round: normalises the 48-bit significand product, rounds it to 24 bits
// and produces the final biased exponent with overflow/underflow indications.
// Build option: FPM_ROUND_NEAREST_EN selects round-to-nearest-even, otherwise truncation.
module fpm_norm_round
    import fpm_pkg::*;
(
    input  logic [47:0]               mant_i,
    input  logic signed [EXPS_W-1:0]  exp_i,
    output logic [FRAC_W-1:0]         frac_o,
    output logic [EXP_W-1:0]          exp_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    logic [23:0]              sig;
    logic signed [EXPS_W-1:0] expNorm;
    logic signed [EXPS_W-1:0] expFinal;
    logic [24:0]              rounded;

    // Pick the 24 significant bits depending on whether the product reached bit 47
    always_comb begin
        if (mant_i[47]) begin
            sig     = mant_i[47:24];
            expNorm = exp_i + 10'sd1;
        end else begin
            sig     = mant_i[46:23];
            expNorm = exp_i;
        end
    end

`ifdef FPM_ROUND_NEAREST_EN
    logic [23:0] discard;
    logic        guardBit;
    logic        stickyBit;
    logic        roundUp;

    assign discard   = mant_i[47] ? mant_i[23:0] : {mant_i[22:0], 1'b0};
    assign guardBit  = discard[23];
    assign stickyBit = |discard[22:0];
    assign roundUp   = guardBit & (stickyBit | sig[0]);
    assign rounded   = {1'b0, sig} + {24'd0, roundUp};
`else
    logic unusedLowBits;

    assign unusedLowBits = ^mant_i[22:0];
    assign rounded       = {1'b0, sig};
`endif

    // A carry out of rounding means the significand became 2.0: renormalise
    always_comb begin
        if (rounded[24]) begin
            frac_o   = rounded[23:1];
            expFinal = expNorm + 10'sd1;
        end else begin
            frac_o   = rounded[22:0];
            expFinal = expNorm;
        end
        exp_o       = expFinal[EXP_W-1:0];
        overflow_o  = (expFinal >= 10'(EXP_MAX));
        underflow_o = (expFinal <= 10'sd0);
    end

endmodule

// File: rtl/fp32_multiplier.sv
// fp32_multiplier: two-stage pipelined IEEE-754 single-precision multiplier.
// Stage 1 classifies operands and forms sign, exponent sum and significand product;
// stage 2 normalises/rounds and resolves special cases. Denormals flush to zero.
// Build option: FPM_ROUND_NEAREST_EN enables round-to-nearest-even (default truncates).
module fp32_multiplier
    import fpm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] product,
    output logic        overflow
);

    opClass_e clsA;
    opClass_e clsB;
    stage1_t  s1_d;
    stage1_t  s1_q;
    logic     s1Valid_q;

    logic [FRAC_W-1:0] nrFrac;
    logic [EXP_W-1:0]  nrExp;
    logic              nrOverflow;
    logic              nrUnderflow;

    logic [31:0] product_d;
    logic [31:0] product_q;
    logic        overflow_d;
    logic        overflow_q;
    logic        outValid_q;

    assign clsA = classify(a);
    assign clsB = classify(b);

    // Stage-1 next state: result class by priority, sign, exponent sum, significand product
    always_comb begin
        s1_d      = '0;
        s1_d.sign = a[31] ^ b[31];
        if (clsA == NAN || clsB == NAN ||
            (clsA == ZERO && clsB == INF) || (clsA == INF && clsB == ZERO)) begin
            s1_d.cls = NAN;
        end else if (clsA == INF || clsB == INF) begin
            s1_d.cls = INF;
        end else if (clsA == ZERO || clsB == ZERO) begin
            s1_d.cls = ZERO;
        end else begin
            s1_d.cls = NORMAL;
        end
        s1_d.expSum = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'(EXP_BIAS);
        s1_d.mant   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    end

    // Stage-1 registers: valid bit always follows in_valid, data only loads on a valid op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1_q      <= '0;
        end else begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    fpm_norm_round u_norm_round (
        .mant_i      (s1_q.mant),
        .exp_i       (s1_q.expSum),
        .frac_o      (nrFrac),
        .exp_o       (nrExp),
        .overflow_o  (nrOverflow),
        .underflow_o (nrUnderflow)
    );

    // Stage-2 next state: special classes bypass the normalised result entirely
    always_comb begin
        product_d  = '0;
        overflow_d = 1'b0;
        unique case (s1_q.cls)
            NAN: begin
                product_d = QNAN;
            end
            INF: begin
                product_d = {s1_q.sign, 8'hFF, 23'd0};
            end
            ZERO: begin
                product_d = {s1_q.sign, 31'd0};
            end
            default: begin
                if (nrOverflow) begin
                    product_d  = {s1_q.sign, 8'hFF, 23'd0};
                    overflow_d = 1'b1;
                end else if (nrUnderflow) begin
                    product_d = {s1_q.sign, 31'd0};
                end else begin
                    product_d = {s1_q.sign, nrExp, nrFrac};
                end
            end
        endcase
    end

    // Stage-2 registers: output valid follows stage-1 valid, data only loads on a valid op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                product_q  <= product_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign out_valid = outValid_q;
    assign product   = product_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// tb_fp32_multiplier: directed and randomized self-checking bench for fp32_multiplier.
// Expected results come from an arithmetic reference model of IEEE-754 multiply
// (flush-to-zero, canonical NaN); FPM_ROUND_NEAREST_EN selects RNE in the model too.
module tb_fp32_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] product;
    logic        overflow;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] prod;
        logic        ovf;
        int          due;
        bit          tol;
    } expect_t;

    expect_t sb[$];
    int      cycle     = 0;
    int      testsRun  = 0;
    int      failCount = 0;

    fp32_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .product   (product),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact significand product, scaled and rounded arithmetically
    function automatic void refModel(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] p, output logic o);
        logic            sgn;
        int              ex, ey, e, sh;
        bit              xNan, yNan, xInf, yInf, xZero, yZero;
        longint unsigned m, sig;
`ifdef FPM_ROUND_NEAREST_EN
        longint unsigned rem, half;
`endif
        sgn   = x[31] ^ y[31];
        ex    = int'(x[30:23]);
        ey    = int'(y[30:23]);
        xNan  = (ex == 255) && (x[22:0] != 0);
        yNan  = (ey == 255) && (y[22:0] != 0);
        xInf  = (ex == 255) && (x[22:0] == 0);
        yInf  = (ey == 255) && (y[22:0] == 0);
        xZero = (ex == 0);
        yZero = (ey == 0);
        o     = 1'b0;
        if (xNan || yNan || (xZero && yInf) || (xInf && yZero)) begin
            p = 32'h7FFF_FFFF;
        end else if (xInf || yInf) begin
            p = {sgn, 8'hFF, 23'd0};
        end else if (xZero || yZero) begin
            p = {sgn, 31'd0};
        end else begin
            m  = (64'h80_0000 + 64'(x[22:0])) * (64'h80_0000 + 64'(y[22:0]));
            e  = ex + ey - 127;
            sh = (m >= (64'd1 << 47)) ? 24 : 23;
            if (sh == 24) e = e + 1;
            sig = m >> sh;
`ifdef FPM_ROUND_NEAREST_EN
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
            if (sig == (64'd1 << 24)) begin
                sig = sig >> 1;
                e   = e + 1;
            end
`endif
            if (e >= 255) begin
                p = {sgn, 8'hFF, 23'd0};
                o = 1'b1;
            end else if (e <= 0) begin
                p = {sgn, 31'd0};
            end else begin
                p = {sgn, e[7:0], sig[22:0]};
            end
        end
    endfunction

    // Operand mix biased towards normal numbers, with specials and extreme exponents
    function automatic logic [31:0] genOperand();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0:       r[30:23] = 8'h00;
            1:       begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            2:       begin r[30:23] = 8'hFF; r[22] = 1'b1; end
            3:       r[30:23] = 8'($urandom_range(180, 254));
            4:       r[30:23] = 8'($urandom_range(1, 60));
            default: r[30:23] = 8'($urandom_range(90, 164));
        endcase
        return r;
    endfunction

    // Checks the outputs visible this cycle against the head of the scoreboard
    task automatic checkOutput();
        expect_t e;
        bit      late;
        bit      ok;
        int      d;
        if (out_valid === 1'b1) begin
            testsRun++;
            assert (sb.size() != 0) else begin
                failCount++;
                $error("[TB] FAIL unexpected_out_valid got product=%h required no output", product);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                testsRun++;
                assert (cycle === e.due) else begin
                    failCount++;
                    $error("[TB] FAIL latency %h*%h got cycle %0d required cycle %0d", e.opA, e.opB, cycle, e.due);
                end
                if (e.tol) begin
                    d  = int'({1'b0, product[30:0]}) - int'({1'b0, e.prod[30:0]});
                    ok = (product[31] === e.prod[31]) && (d >= -1) && (d <= 1);
                end else begin
                    ok = (product === e.prod);
                end
                testsRun++;
                assert (ok === 1'b1) else begin
                    failCount++;
                    $error("[TB] FAIL product %h*%h got %h required %h", e.opA, e.opB, product, e.prod);
                end
                testsRun++;
                assert (overflow === e.ovf) else begin
                    failCount++;
                    $error("[TB] FAIL overflow %h*%h got %b required %b", e.opA, e.opB, overflow, e.ovf);
                end
            end
        end else begin
            late = (sb.size() != 0) && (sb[0].due <= cycle);
            testsRun++;
            assert (late === 1'b0) else begin
                failCount++;
                $error("[TB] FAIL missing_output got out_valid=%b required 1 at cycle %0d", out_valid, cycle);
            end
        end
    endtask

    // One cycle: check what is visible, then drive the next op (or a bubble)
    task automatic applyStimulus(input bit v, input logic [31:0] x, input logic [31:0] y,
                                 input bit directed, input logic [31:0] expP,
                                 input bit expO, input bit tol);
        expect_t     e;
        logic [31:0] p;
        logic        o;
        @(negedge clk);
        cycle++;
        checkOutput();
        in_valid = v;
        a        = x;
        b        = y;
        if (v) begin
            if (directed) begin
                p = expP;
                o = expO;
            end else begin
                refModel(x, y, p, o);
            end
            e.opA  = x;
            e.opB  = y;
            e.prod = p;
            e.ovf  = o;
            e.due  = cycle + 2;
            e.tol  = tol;
            sb.push_back(e);
        end
    endtask

    localparam int ND = 14;
    logic [31:0] dA [ND];
    logic [31:0] dB [ND];
    logic [31:0] dP [ND];
    bit          dO [ND];
    bit          dT [ND];

    initial begin
        dA = '{32'h4201_9999, 32'hC207_C28F, 32'h4207_C28F, 32'hC242_B852, 32'h0000_0000,
               32'h0000_0000, 32'h60AD_78EB, 32'h60AD_78EB, 32'h60AD_78EB, 32'h7F80_0000,
               32'h0040_0000, 32'h3F80_0000, 32'h0080_0000, 32'h7F7F_FFFF};
        dB = '{32'h4124_CCCC, 32'h4243_B852, 32'hC243_B852, 32'h0000_0000, 32'hC242_B852,
               32'h7F80_0000, 32'h60AD_78EB, 32'h7F80_0000, 32'h7FFF_FFFF, 32'hC000_0000,
               32'h3F80_0000, 32'h3F80_0000, 32'h0080_0000, 32'h4000_0000};
        dP = '{32'h43A6_DC28, 32'hC4CF_95E4, 32'hC4CF_95E4, 32'h8000_0000, 32'h8000_0000,
               32'h7FFF_FFFF, 32'h7F80_0000, 32'h7F80_0000, 32'h7FFF_FFFF, 32'hFF80_0000,
               32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
        dO = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        dT = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        testsRun++;
        assert (out_valid === 1'b0) else begin
            failCount++;
            $error("[TB] FAIL reset_out_valid got %b required 0", out_valid);
        end
        testsRun++;
        assert (product === 32'h0) else begin
            failCount++;
            $error("[TB] FAIL reset_product got %h required 00000000", product);
        end
        testsRun++;
        assert (overflow === 1'b0) else begin
            failCount++;
            $error("[TB] FAIL reset_overflow got %b required 0", overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed operands, back to back");
        for (int i = 0; i < ND; i++) begin
            applyStimulus(1'b1, dA[i], dB[i], 1'b1, dP[i], dO[i], dT[i]);
        end
        repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] reset with two ops in flight");
        applyStimulus(1'b1, 32'h3FC0_0000, 32'h4040_0000, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h60AD_78EB, 32'h60AD_78EB, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        cycle++;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        testsRun++;
        assert (out_valid === 1'b0) else begin
            failCount++;
            $error("[TB] FAIL midreset_out_valid got %b required 0", out_valid);
        end
        testsRun++;
        assert (product === 32'h0) else begin
            failCount++;
            $error("[TB] FAIL midreset_product got %h required 00000000", product);
        end
        testsRun++;
        assert (overflow === 1'b0) else begin
            failCount++;
            $error("[TB] FAIL midreset_overflow got %b required 0", overflow);
        end
        sb.delete();
        @(negedge clk);
        cycle++;
        rst_n = 1'b1;
        repeat (5) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] randomized stream");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 85), genOperand(), genOperand(),
                          1'b0, 32'h0, 1'b0, 1'b0);
        end
        repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        testsRun++;
        assert (sb.size() == 0) else begin
            failCount++;
            $error("[TB] FAIL drain got %0d pending results required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/fp32_multiplier.md
# fp32_multiplier

Pipelined IEEE-754 single-precision multiplier with special-value handling and an exponent-overflow flag. It sits in the arithmetic datapath as a leaf block. It accepts one operand pair per clock and returns the product two cycles later. Denormals are flushed to zero; NaN results are canonical.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  operands valid this cycle.
- `a`  input  32  operand A (sign[31], exp[30:23], frac[22:0]).
- `b`  input  32  operand B.
- `out_valid`  output  1  `product`/`overflow` valid.
- `product`  output  32  A×B.
- `overflow`  output  1  finite operands produced a result exponent above 254.

## Operation
- Sign is always a[31]^b[31], except NaN results.
- Special cases, first match wins:
  - Either operand NaN (exp=255, frac≠0): product = 32'h7FFF_FFFF.
  - 0×inf or inf×0: product = 32'h7FFF_FFFF.
  - Either operand inf: product = {sign, 8'hFF, 23'd0}.
  - Either operand zero or denormal (exp=0): product = {sign, 31'd0}, so −48.93×0 = 32'h8000_0000.
- `overflow` is 0 for every special case.
- Normal path:
  - Mantissas are {1,frac}, 24×24 → 48-bit product.
  - Exponent sum is a[30:23]+b[30:23]−127, computed in 10-bit signed arithmetic.
  - If product bit 47 is set, shift right by 1 and add 1 to the exponent.
  - Round per Configuration. A mantissa carry-out after rounding renormalises and increments the exponent again.
- Final exponent ≥255: product = {sign, 8'hFF, 23'd0}, overflow = 1.
- Final exponent ≤0: product = {sign, 31'd0}, overflow = 0. There is no separate underflow output.

## Timing
- Stage 1 registers the special-case class, sign, exponent sum and the 48-bit mantissa product.
- Stage 2 registers the normalised and rounded result.
- Latency: `in_valid` sampled at edge N → `out_valid`, `product`, `overflow` valid after edge N+2.
- Fully pipelined with one op per cycle and no backpressure.
- `out_valid` is a delayed copy of `in_valid`.
- Data registers update only when their stage is valid and hold otherwise.
- Reset values: `out_valid`=0, `product`=0, `overflow`=0, all internal stage-valid bits 0.
- Reset asserted mid-operation discards in-flight ops; no `out_valid` follows for them.
- Back-to-back ops with mixed special/normal classes must not interfere.

## Configuration
- `FPM_ROUND_NEAREST_EN` defined: round-to-nearest-even using guard, round and sticky bits from the discarded 24 low product bits.
- Undefined: truncate (round toward zero). The result may differ from the RNE result by 1 ulp.
- Both builds must produce identical special-case and overflow behaviour.

## Structure
- Package `fpm_pkg` holds:
  - `EXP_BIAS`=127, `EXP_MAX`=255, `QNAN`=32'h7FFF_FFFF.
  - Field widths (8 exp, 23 frac).
  - An enum for operand class (ZERO, NORMAL, INF, NAN).
  - A stage-1 struct type.
- Sub-module `fpm_norm_round`: combinational block taking the 48-bit mantissa product and 10-bit exponent, returning the 23-bit fraction, final exponent and overflow/underflow. The rounding macro is confined here.

## Test plan
Compare results within ±1 ulp for normal cases; special cases must match exactly.
- 32'h4201_9999 × 32'h4124_CCCC (32.4×10.3) → 32'h43A6_DC28, overflow 0, out_valid two cycles after in_valid.
- 32'hC207_C28F × 32'h4243_B852 (−33.94×48.93) → 32'hC4CF_95E4. Swapped signs give the same result.
- 32'hC242_B852 × 32'h0000_0000 → 32'h8000_0000, and the reversed operand order gives the same. 32'h0000_0000 × 32'h7F80_0000 → 32'h7FFF_FFFF. All have overflow 0.
- 32'h60AD_78EB × 32'h60AD_78EB → 32'h7F80_0000, overflow 1.
- 32'h60AD_78EB × 32'h7F80_0000 → 32'h7F80_0000, overflow 0. 32'h60AD_78EB × 32'h7FFF_FFFF → 32'h7FFF_FFFF.
- Streaming and reset:
  - Six different ops on consecutive cycles → results in order, one per cycle.
  - Assert `rst_n` low with two ops in flight → `out_valid`, `product`, `overflow` are 0 immediately, and no stale outputs appear after release.
